// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: issues sequential word reads to instruction memory,
// buffers returned words with their NPC, and hands them to fetch via valid/ready.
module instr_prefetch_queue #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
) (
  input  logic                     clk1,
  input  logic                     rst,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  input  logic                     halt,
  output logic                     mem_req,
  output logic [ADDR_W-1:0]        mem_addr,
  input  logic                     mem_rvalid,
  input  logic [DATA_W-1:0]        mem_rdata,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_ir,
  output logic [31:0]              out_npc,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  logic [31:0]       fetch_pc;
  logic [31:0]       inflight_pc;
  logic              inflight;
  logic              stale;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [CW-1:0]     count_q;
  logic [DATA_W-1:0] ir_mem  [DEPTH];
  logic [31:0]       npc_mem [DEPTH];

  logic [CW:0]       occupancy;
  logic              issue;
  logic              resp;
  logic              push;
  logic              pop;

  assign out_valid = (count_q != '0);
  assign mem_req   = issue;
  assign mem_addr  = fetch_pc[ADDR_W-1:0];
  assign count     = count_q;
  assign out_ir    = out_valid ? ir_mem[rd_ptr]  : '0;
  assign out_npc   = out_valid ? npc_mem[rd_ptr] : '0;

  // Credit counts the outstanding read so a returning word always has a slot.
  always_comb begin
    occupancy = {1'b0, count_q} + {{CW{1'b0}}, inflight};
    issue     = !rst && !halt && !redirect && (occupancy < DEPTH_C);
    resp      = mem_rvalid && inflight;
    push      = resp && !stale && !redirect;
    pop       = out_valid && out_ready && !redirect;
  end

  always_ff @(posedge clk1) begin
    if (push && !rst) begin
      ir_mem[wr_ptr]  <= mem_rdata;
      npc_mem[wr_ptr] <= inflight_pc + 32'd1;
    end
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      fetch_pc    <= '0;
      inflight_pc <= '0;
      inflight    <= 1'b0;
      stale       <= 1'b0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count_q     <= '0;
    end else if (redirect) begin
      fetch_pc <= redirect_pc;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count_q  <= '0;
      // A read still owed next cycle belongs to the old path: mark it for discard.
      stale    <= inflight && !mem_rvalid;
      inflight <= inflight && !mem_rvalid;
    end else begin
      if (issue) begin
        inflight    <= 1'b1;
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + 32'd1;
        stale       <= 1'b0;
      end else if (resp) begin
        inflight <= 1'b0;
      end
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: doc/instr_prefetch_queue.md
Name: instr_prefetch_queue

Overview:
- Instruction prefetch unit upstream of the IF/ID latch. Fetches 32-bit instruction words from word-addressed instruction memory and buffers them in a small FIFO.
- Presents each buffered instruction with its NPC (PC+1) to the fetch stage through a valid/ready handshake.
- Supports branch redirect (flush) and halt.

Parameters:
DEPTH, 4, number of FIFO entries (power of 2, min 2)
ADDR_W, 10, instruction memory address width (1024 words)
DATA_W, 32, instruction word width

Ports:
clk1  in  1  single clock; all state updates on posedge clk1
rst  in  1  synchronous active-high reset
redirect  in  1  taken-branch flush request
redirect_pc  in  32  new fetch address, sampled when redirect=1
halt  in  1  stop issuing new memory requests
mem_req  out  1  read request to instruction memory
mem_addr  out  ADDR_W  read address, equals fetch_pc[ADDR_W-1:0]
mem_rvalid  in  1  read data valid, exactly 1 cycle after mem_req
mem_rdata  in  DATA_W  instruction word
out_valid  out  1  head entry available
out_ir  out  DATA_W  head instruction
out_npc  out  32  head PC+1
out_ready  in  1  consumer accepts head
count  out  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
Internal state:
- fetch_pc (32b), inflight (1b), inflight_pc (32b), stale (1b), FIFO storage, rd/wr pointers, count.

Reset (rst=1 at posedge):
- fetch_pc=0, inflight=0, stale=0, pointers=0, count=0.
- Outputs: mem_req=0, out_valid=0, out_ir=0, out_npc=0.

Issue:
- mem_req is combinational from registered state: mem_req = !rst && !halt && !redirect && (count + inflight < DEPTH).
- The credit check uses registered count. A same-cycle pop does not free a slot for issue.
- On issue: inflight<=1, inflight_pc<=fetch_pc, fetch_pc<=fetch_pc+1, stale<=0.
- fetch_pc wraps 32'hFFFFFFFF -> 0. mem_addr truncates fetch_pc to ADDR_W bits.

Response:
- When mem_rvalid=1 and inflight=1, inflight clears (unless a new issue sets it in the same cycle).
- If stale=0 and redirect=0, push {mem_rdata, inflight_pc+1} at wr_ptr.
- If stale=1, discard the data.
- mem_rvalid while inflight=0 is ignored.
- Sustained throughput is 1 instruction/cycle when out_ready=1.

Output:
- out_valid = (count != 0).
- out_ir/out_npc are driven from the head entry, and are 0 when count==0.
- Pop occurs when out_valid && out_ready.
- Push and pop in the same cycle leave count unchanged.
- Overflow is impossible by the credit rule. Underflow is impossible because pop is gated by out_valid.

Redirect (highest priority, below rst):
- Pointers and count clear. fetch_pc<=redirect_pc.
- No issue in the redirect cycle.
- If inflight=1 (response due next cycle), or a response arrives in the redirect cycle, that data is dropped: set stale<=1 when inflight=1 and mem_rvalid=0.
- Any pop in the redirect cycle is cancelled.
- Latency: redirect at cycle N -> mem_req at N+1 with mem_addr=redirect_pc -> rvalid at N+2 -> out_valid at N+3, with out_npc=redirect_pc+1.

Halt:
- Blocks new issue only. An in-flight response is still pushed, and the FIFO still drains.
- Deasserting halt resumes at the current fetch_pc.
- Redirect while halted updates fetch_pc and flushes.

Simultaneous events:
- rst > redirect > push/pop.
- Redirect together with mem_rvalid: the response is discarded.

Test Plan:
- Reset: hold rst 2 cycles -> mem_req=0, out_valid=0, count=0. First cycle after release: mem_req=1, mem_addr=0.
- Streaming, mem[i]=32'h100+i, out_ready=1 -> first out_valid 2 cycles after first mem_req. Outputs 100,101,...,107 with npc 1..8 on consecutive cycles, no bubbles.
- Backpressure, out_ready=0 -> count reaches 4, mem_req drops to 0 with exactly 4 requests issued (addr 0..3). Release out_ready -> drain 100..103, then issue resumes at addr 4.
- Redirect, redirect=1 with redirect_pc=20 while a request for addr 5 is in flight -> count=0 next cycle, the addr-5 word never appears. Next out_ir=mem[20], out_npc=21.
- Halt, halt=1 with 2 entries queued and 1 in flight -> count goes to 3, no further mem_req. Entries drain in order. On halt=0, mem_req resumes at the next sequential address.
- Wrap, redirect_pc=32'h3FF then 32'hFFFFFFFF -> mem_addr 3FF, then 000 with out_npc=32'h400. For FFFFFFFF: mem_addr=3FF, out_npc=0, next fetch_pc=0.
